code_loop_ctrl: RTL and testbench

CODE_LOOP_CTRL -- requirements
Module: code_loop_ctrl

---
 rtl/code_loop_ctrl.sv | 171 +++++++++++++++++
 tb/tb_code_loop_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/code_loop_ctrl.sv
// Code-loop lock controller: measures early/late correlator energy per dither cycle and runs SEARCH/VERIFY/TRACK.
// Optional build macro SAT_SCAN_EN: internal PRN scan register stepped on dwell expiry instead of following sat_sel.
module code_loop_ctrl #(
    parameter int THRESH   = 40000,
    parameter int VERIFY_N = 3,
    parameter int LOSS_N   = 8,
    parameter int DWELL    = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       corr,
    input  logic       epoch,
    input  logic       dither,
    input  logic [4:0] sat_sel,
    output logic       codesign,
    output logic       codetrack,
    output logic [4:0] sat
);
    localparam int HIT_W  = (VERIFY_N < 1) ? 1 : $clog2(VERIFY_N + 1);
    localparam int MISS_W = (LOSS_N < 1) ? 1 : $clog2(LOSS_N + 1);
    localparam int DWL_W  = (DWELL < 1) ? 1 : $clog2(DWELL + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, TRACK} state_t;

    logic              corr_meta_q, corr_sync_q;
    logic              epoch_q, dither_q;
    logic [15:0]       cnt_q, cnt_d;
    logic [17:0]       e_q, e_d, l_q, l_d;
    logic              primed_q, primed_d;
    state_t            state_q, state_d;
    logic [HIT_W-1:0]  hit_q, hit_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [DWL_W-1:0]  dwell_q, dwell_d;
    logic              codesign_q, codesign_d;
    logic              codetrack_q, codetrack_d;

    logic        epoch_pulse, dither_pulse, eval, good, dwell_expire;
    logic [18:0] sum_w;

    assign epoch_pulse  = epoch & ~epoch_q;
    assign dither_pulse = dither & ~dither_q;
    assign eval         = dither_pulse & primed_q;
    assign sum_w        = {1'b0, e_q} + {1'b0, l_q};
    assign good         = (sum_w >= 19'(THRESH));

    // A dither edge empties the accumulators first, so a coincident epoch count starts the new cycle.
    always_comb begin
        cnt_d    = cnt_q;
        e_d      = dither_pulse ? 18'd0 : e_q;
        l_d      = dither_pulse ? 18'd0 : l_q;
        primed_d = primed_q | dither_pulse;
        if (epoch_pulse) begin
            cnt_d = 16'd0;
            if (dither) e_d = e_d + {2'b00, cnt_q};
            else        l_d = l_d + {2'b00, cnt_q};
        end else if (corr_sync_q && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        dwell_d      = dwell_q;
        dwell_expire = 1'b0;
        if (eval) begin
            case (state_q)
                SEARCH: begin
                    if (good) begin
                        state_d = VERIFY;
                        hit_d   = HIT_W'(1);
                        miss_d  = '0;
                        dwell_d = '0;
                    end else if (dwell_q + DWL_W'(1) == DWL_W'(DWELL)) begin
                        dwell_d      = '0;
                        dwell_expire = 1'b1;
                    end else begin
                        dwell_d = dwell_q + DWL_W'(1);
                    end
                end
                VERIFY: begin
                    if (!good) begin
                        state_d = SEARCH;
                        hit_d   = '0;
                        miss_d  = '0;
                    end else if (hit_q + HIT_W'(1) == HIT_W'(VERIFY_N)) begin
                        state_d = TRACK;
                        hit_d   = '0;
                        miss_d  = '0;
                    end else begin
                        hit_d = hit_q + HIT_W'(1);
                    end
                end
                TRACK: begin
                    if (good) begin
                        miss_d = '0;
                    end else if (miss_q + MISS_W'(1) == MISS_W'(LOSS_N)) begin
                        state_d = SEARCH;
                        hit_d   = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + MISS_W'(1);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
        codetrack_d = (state_d == TRACK);
        // The evaluation that enters TRACK already steers the loop.
        if (state_d != TRACK) codesign_d = 1'b0;
        else if (eval)        codesign_d = (l_q >= e_q);
        else                  codesign_d = codesign_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            corr_meta_q <= 1'b0;
            corr_sync_q <= 1'b0;
            epoch_q     <= 1'b0;
            dither_q    <= 1'b0;
            cnt_q       <= '0;
            e_q         <= '0;
            l_q         <= '0;
            primed_q    <= 1'b0;
            state_q     <= SEARCH;
            hit_q       <= '0;
            miss_q      <= '0;
            dwell_q     <= '0;
            codesign_q  <= 1'b0;
            codetrack_q <= 1'b0;
        end else begin
            corr_meta_q <= corr;
            corr_sync_q <= corr_meta_q;
            epoch_q     <= epoch;
            dither_q    <= dither;
            cnt_q       <= cnt_d;
            e_q         <= e_d;
            l_q         <= l_d;
            primed_q    <= primed_d;
            state_q     <= state_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            dwell_q     <= dwell_d;
            codesign_q  <= codesign_d;
            codetrack_q <= codetrack_d;
        end
    end

    assign codesign  = codesign_q;
    assign codetrack = codetrack_q;

`ifdef SAT_SCAN_EN
    logic [4:0] sat_q;
    logic       unused_sat_sel;

    // PRN 0 is not a valid satellite, so the scan wraps 31 -> 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              sat_q <= 5'd1;
        else if (dwell_expire) sat_q <= (sat_q == 5'd31) ? 5'd1 : sat_q + 5'd1;
    end

    assign sat            = sat_q;
    assign unused_sat_sel = ^sat_sel;
`else
    logic unused_expire;

    assign sat           = sat_sel;
    assign unused_expire = dwell_expire;
`endif
endmodule

// File: tb/tb_code_loop_ctrl.sv
// Randomised bench for code_loop_ctrl: shortened epochs, per-epoch corr counts, dither-cycle reference model.
module tb_code_loop_ctrl;
    localparam int THRESH   = 100;
    localparam int VERIFY_N = 2;
    localparam int LOSS_N   = 2;
    localparam int DWELL    = 3;
    localparam int EP       = 80;
    localparam int M_SEARCH = 0;
    localparam int M_VERIFY = 1;
    localparam int M_TRACK  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       corr = 1'b0;
    logic       epoch = 1'b0;
    logic       dither = 1'b0;
    logic [4:0] sat_sel = 5'd7;
    logic       codesign, codetrack;
    logic [4:0] sat;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int m_state, m_hit, m_miss, m_dwell, m_primed, m_sign, m_sat;
    int prev_e, prev_l;

    code_loop_ctrl #(
        .THRESH(THRESH), .VERIFY_N(VERIFY_N), .LOSS_N(LOSS_N), .DWELL(DWELL)
    ) dut (
        .clk(clk), .rst(rst), .corr(corr), .epoch(epoch), .dither(dither),
        .sat_sel(sat_sel), .codesign(codesign), .codetrack(codetrack), .sat(sat)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end else begin
            $display("ok   %s cycle %0d: %0d", tag, cyc, obs);
        end
    endtask

    task automatic model_reset();
        m_state = M_SEARCH; m_hit = 0; m_miss = 0; m_dwell = 0;
        m_primed = 0; m_sign = 0; m_sat = 1; prev_e = 0; prev_l = 0;
    endtask

    // One evaluation of the lock rules on a finished dither cycle's early/late energy.
    task automatic model_eval(input int e, input int l);
        bit hit_ok;
        hit_ok = (e + l) >= THRESH;
        if (m_state == M_SEARCH) begin
            if (hit_ok) begin
                m_state = M_VERIFY; m_hit = 1; m_miss = 0; m_dwell = 0;
            end else begin
                m_dwell++;
                if (m_dwell == DWELL) begin
                    m_dwell = 0;
                    m_sat = (m_sat == 31) ? 1 : m_sat + 1;
                end
            end
        end else if (m_state == M_VERIFY) begin
            if (!hit_ok) begin
                m_state = M_SEARCH; m_hit = 0; m_miss = 0;
            end else begin
                m_hit++;
                if (m_hit == VERIFY_N) begin
                    m_state = M_TRACK; m_hit = 0; m_miss = 0;
                end
            end
        end else begin
            if (hit_ok) m_miss = 0;
            else begin
                m_miss++;
                if (m_miss == LOSS_N) begin
                    m_state = M_SEARCH; m_hit = 0; m_miss = 0;
                end
            end
        end
        m_sign = (m_state == M_TRACK) ? int'(l >= e) : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 80-clk epoch; corr is high for n clks well away from both edges.
    task automatic run_epoch(input bit chg, input bit dval, input int n);
        for (int t = 0; t < EP; t++) begin
            epoch = (t < EP / 2);
            if (chg && t == 4) dither = dval;
            corr = (t >= 8 && t < 8 + n);
            tick();
        end
    endtask

    task automatic lead_in();
        for (int i = 0; i < 3; i++) run_epoch(1'b0, 1'b0, 64);
    endtask

    task automatic check_outputs();
        sat_sel = 5'($urandom_range(0, 31));
        #1;
        check_val("codetrack", {31'd0, codetrack}, (m_state == M_TRACK) ? 1 : 0);
        check_val("codesign", {31'd0, codesign}, m_sign);
`ifdef SAT_SCAN_EN
        check_val("sat", {27'd0, sat}, m_sat);
`else
        check_val("sat", {27'd0, sat}, {27'd0, sat_sel});
`endif
    endtask

    task automatic run_cycle(input int e0, input int e1, input int e2,
                             input int l0, input int l1, input int l2);
        cyc++;
        if (m_primed != 0) model_eval(prev_e, prev_l);
        else m_primed = 1;
        prev_e = e0 + e1 + e2;
        prev_l = l0 + l1 + l2;
        run_epoch(1'b1, 1'b1, e0);
        check_outputs();
        run_epoch(1'b0, 1'b0, e1);
        run_epoch(1'b0, 1'b0, e2);
        run_epoch(1'b1, 1'b0, l0);
        run_epoch(1'b0, 1'b0, l1);
        run_epoch(1'b0, 1'b0, l2);
    endtask

    task automatic apply_reset();
        rst = 1'b0; corr = 1'b0; epoch = 1'b0; dither = 1'b0;
        model_reset();
        repeat (4) tick();
        rst = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        check_val("rst_codetrack", {31'd0, codetrack}, 0);
        check_val("rst_codesign", {31'd0, codesign}, 0);
`ifdef SAT_SCAN_EN
        check_val("rst_sat", {27'd0, sat}, m_sat);
`else
        check_val("rst_sat", {27'd0, sat}, {27'd0, sat_sel});
`endif
        rst = 1'b1;
        repeat (4) tick();
        lead_in();

        // acquisition with strong signal
        for (int i = 0; i < 4; i++) run_cycle(64, 64, 64, 64, 64, 64);
        // late-heavy then early-heavy discriminator
        for (int i = 0; i < 2; i++) run_cycle(40, 40, 40, 60, 60, 60);
        for (int i = 0; i < 2; i++) run_cycle(60, 60, 60, 40, 40, 40);
        // loss: one good cycle in between resets the miss count
        run_cycle(0, 0, 0, 0, 0, 0);
        run_cycle(64, 64, 64, 64, 64, 64);
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 0, 0);
        // dwell expiry
        for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 0, 0, 0);
        // threshold edges: 99 misses, 100 hits, E==L steers late
        run_cycle(17, 17, 17, 16, 16, 16);
        run_cycle(17, 17, 17, 17, 16, 16);
        run_cycle(17, 17, 16, 17, 17, 16);
        run_cycle(17, 17, 17, 16, 16, 16);
        run_cycle(17, 17, 16, 17, 17, 16);
        run_cycle(17, 17, 17, 16, 16, 16);
        run_cycle(17, 17, 17, 16, 16, 16);
        run_cycle(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            int hi;
            int c[6];
            hi = ($urandom_range(0, 3) == 0) ? 5 : 40;
            for (int k = 0; k < 6; k++) c[k] = $urandom_range(0, hi);
            run_cycle(c[0], c[1], c[2], c[3], c[4], c[5]);
        end

        // reach TRACK, then reset in the middle of a dither cycle
        for (int i = 0; i < 4; i++) run_cycle(64, 64, 64, 64, 64, 64);
        run_epoch(1'b1, 1'b1, 30);
        rst = 1'b0;
        model_reset();
        #1;
        check_val("rst_async_codetrack", {31'd0, codetrack}, (m_state == M_TRACK) ? 1 : 0);
        check_val("rst_async_codesign", {31'd0, codesign}, m_sign);
        corr = 1'b0; epoch = 1'b0; dither = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        repeat (4) tick();
        lead_in();
        for (int i = 0; i < 4; i++) run_cycle(64, 64, 64, 64, 64, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
